// File: rtl/mhp_pkg.sv
// Shared constants, FSM encoding and small helpers for the MHP receive arbiter.
package mhp_pkg;

  // Frame-start byte the decoder consumes before each forwarded frame.
  localparam logic [7:0] MHP_PREAMBLE   = 8'h55;
  // Longest frame the decoder accepts: 7 header bytes plus 42 payload bytes.
  localparam int         MHP_FRAME_MAX  = 49;
  // Idle cycles on the stream after each frame.
  localparam int         MHP_GAP_CYCLES = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_STREAM   = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_GAP      = 3'd4
  } mhp_state_e;

  // Saturating 8-bit increment used by the abort counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/mhp_rr_pick.sv
// Round-robin selector: picks the first requester after the last grant.
module mhp_rr_pick #(
  parameter int N_REQ = 4,
  parameter int GW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [GW-1:0]    i_last,
  output logic             o_any,
  output logic [GW-1:0]    o_idx
);

  // Rank every requester by its distance after i_last and keep the nearest active one.
  always_comb begin
    int v_dist;
    int v_best;
    v_dist = 0;
    v_best = N_REQ;
    o_any  = 1'b0;
    o_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // distance 0 is the requester right after the last grant
      v_dist = (k + N_REQ - 1 - int'(i_last)) % N_REQ;
      if (i_req[k] && (v_dist < v_best)) begin
        v_best = v_dist;
        o_idx  = GW'(k);
        o_any  = 1'b1;
      end else begin
      end
    end
  end

endmodule

// File: rtl/mhp_rx_arbiter.sv
// Arbitrates N_REQ byte-stream requesters onto one frame-decoder stream.
// Each frame is prefixed with a preamble byte, capped at FRAME_MAX bytes,
// cut short when the source stalls, and followed by an idle gap.
module mhp_rx_arbiter
  import mhp_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = MHP_GAP_CYCLES,
  parameter int FRAME_MAX  = MHP_FRAME_MAX
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [8*N_REQ-1:0]         i_req_data,
  input  logic [N_REQ-1:0]           i_req_valid,
  input  logic [N_REQ-1:0]           i_req_last,
  output logic [N_REQ-1:0]           o_req_ready,
  output logic [7:0]                 o_rdata,
  output logic                       o_rvalid,
  output logic [$clog2(N_REQ)-1:0]   o_grant,
  output logic                       o_busy,
  output logic [15:0]                o_frame_cnt,
  output logic [7:0]                 o_abort_cnt
);

  localparam int GW  = $clog2(N_REQ);
  localparam int BCW = $clog2(FRAME_MAX + 1);
  localparam int GCW = $clog2(GAP_CYCLES + 1);

  mhp_state_e       r_state;
  mhp_state_e       w_state_nxt;

  // r_grant doubles as the round-robin "last grant" pointer.
  logic [GW-1:0]    r_grant;
  logic [GW-1:0]    w_grant_nxt;
  logic [GW-1:0]    w_pick_idx;
  logic             w_pick_any;

  logic [7:0]       r_rdata;
  logic [7:0]       w_rdata_nxt;
  logic             r_rvalid;
  logic             w_rvalid_nxt;
  logic [BCW-1:0]   r_byte_cnt;
  logic [BCW-1:0]   w_byte_cnt_nxt;
  logic [GCW-1:0]   r_gap_cnt;
  logic [GCW-1:0]   w_gap_cnt_nxt;
  logic [15:0]      r_frame_cnt;
  logic [7:0]       r_abort_cnt;
  logic             w_frame_inc;
  logic             w_abort_inc;

  logic [7:0]       w_gdata;
  logic             w_gvalid;
  logic             w_glast;
  logic             w_acc_state;
  logic             w_at_cap;
  logic [N_REQ-1:0] w_ready;

  mhp_rr_pick #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_pick (
    .i_req  (i_req_valid),
    .i_last (r_grant),
    .o_any  (w_pick_any),
    .o_idx  (w_pick_idx)
  );

  // Route the granted requester's byte, valid and last onto internal wires.
  always_comb begin
    w_gdata  = 8'h00;
    w_gvalid = 1'b0;
    w_glast  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_grant == GW'(k)) begin
        w_gdata  = i_req_data[8*k +: 8];
        w_gvalid = i_req_valid[k];
        w_glast  = i_req_last[k];
      end else begin
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = ST_PREAMBLE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PREAMBLE: begin
        w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (!w_gvalid) begin
          w_state_nxt = ST_FLUSH;
        end else if (w_glast) begin
          w_state_nxt = ST_GAP;
        end else if (w_at_cap) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_state_nxt = ST_STREAM;
        end
      end
      ST_FLUSH: begin
        if (w_gvalid && w_glast) begin
          w_state_nxt = ST_GAP;
        end else begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_GAP: begin
        // the first gap cycle may still show the final byte; only idle cycles count
        if (!r_rvalid && (r_gap_cnt == GCW'(GAP_CYCLES - 1))) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_GAP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode: ready towards the granted source and next values of the registered stream.
  always_comb begin
    w_acc_state    = (r_state == ST_STREAM) || (r_state == ST_FLUSH);
    w_at_cap       = (r_byte_cnt == BCW'(FRAME_MAX - 1));
    w_ready        = '0;
    w_rvalid_nxt   = 1'b0;
    w_rdata_nxt    = r_rdata;
    w_byte_cnt_nxt = '0;
    w_gap_cnt_nxt  = '0;
    w_grant_nxt    = r_grant;
    w_frame_inc    = 1'b0;
    w_abort_inc    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      w_ready[k] = w_acc_state && (r_grant == GW'(k));
    end
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_grant_nxt = w_pick_idx;
        end else begin
          w_grant_nxt = r_grant;
        end
      end
      ST_PREAMBLE: begin
        // preamble is launched here so the first data byte follows it back-to-back
        w_rvalid_nxt = 1'b1;
        w_rdata_nxt  = MHP_PREAMBLE;
      end
      ST_STREAM: begin
        if (!w_gvalid) begin
          w_abort_inc = 1'b1;
        end else begin
          w_rvalid_nxt   = 1'b1;
          w_rdata_nxt    = w_gdata;
          w_byte_cnt_nxt = r_byte_cnt + 1'b1;
          if (w_glast) begin
            w_frame_inc = 1'b1;
          end else if (w_at_cap) begin
            w_abort_inc = 1'b1;
          end else begin
          end
        end
      end
      ST_FLUSH: begin
        // bytes are accepted through w_ready and dropped
      end
      ST_GAP: begin
        if (r_rvalid) begin
          w_gap_cnt_nxt = r_gap_cnt;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant     <= GW'(N_REQ - 1);
      r_rdata     <= 8'h00;
      r_rvalid    <= 1'b0;
      r_byte_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_frame_cnt <= 16'h0000;
      r_abort_cnt <= 8'h00;
    end else begin
      r_grant    <= w_grant_nxt;
      r_rdata    <= w_rdata_nxt;
      r_rvalid   <= w_rvalid_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      if (w_frame_inc) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else begin
        r_frame_cnt <= r_frame_cnt;
      end
      if (w_abort_inc) begin
        r_abort_cnt <= sat_inc8(r_abort_cnt);
      end else begin
        r_abort_cnt <= r_abort_cnt;
      end
    end
  end

  assign o_req_ready = w_ready;
  assign o_rdata     = r_rdata;
  assign o_rvalid    = r_rvalid;
  assign o_grant     = r_grant;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_frame_cnt = r_frame_cnt;
  assign o_abort_cnt = r_abort_cnt;

endmodule

// File: doc/mhp_rx_arbiter.md
MHP_RX_ARBITER -- requirements
Module: mhp_rx_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of byte-stream requesters.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 3, giving the idle cycles inserted after each frame.
REQ-003 The block SHALL have parameter FRAME_MAX, default 49, giving the maximum number of bytes forwarded per frame.
REQ-004 The block SHALL have port clk, input, 1 bit: the only clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port i_req_data, input, 8*N_REQ bits: byte of requester k in bits [8k+7:8k].
REQ-007 The block SHALL have ports i_req_valid and i_req_last, input, N_REQ bits each: byte valid and last-byte-of-frame per requester.
REQ-008 The block SHALL have port o_req_ready, output, N_REQ bits: byte accepted from requester k when valid[k]&ready[k].
REQ-009 The block SHALL have ports o_rdata (8 bits) and o_rvalid (1 bit), outputs, forming the byte stream to the frame decoder.
REQ-010 The block SHALL have port o_grant, output, $clog2(N_REQ) bits: the currently or last granted requester.
REQ-011 The block SHALL have port o_busy, output, 1 bit: high in any state other than IDLE.
REQ-012 The block SHALL have ports o_frame_cnt (16 bits, wrapping) and o_abort_cnt (8 bits, saturating at 255), both outputs.

Function
REQ-013 The FSM SHALL have states IDLE, PREAMBLE, STREAM, FLUSH and GAP.
REQ-014 IDLE: when any i_req_valid is high, the block SHALL grant by round-robin, searching from (last grant + 1) mod N_REQ, register o_grant, and go to PREAMBLE.
REQ-015 PREAMBLE: for one cycle the block SHALL drive o_rvalid=1 and o_rdata=MHP_PREAMBLE (8'h55); the decoder discards this byte as its frame-start byte.
REQ-016 o_req_ready[k] SHALL be combinational and equal 1 only when k==o_grant and the state is STREAM or FLUSH.
REQ-017 STREAM, accepted byte: o_rdata/o_rvalid SHALL be registered, so a byte accepted in cycle t appears in cycle t+1; a byte counter increments.
REQ-018 STREAM, accepted byte with last=1: the block SHALL forward the byte, increment o_frame_cnt and go to GAP.
REQ-019 STREAM, granted valid low: the block SHALL drive o_rvalid=0 (ending the decoder frame), increment o_abort_cnt and go to FLUSH.
REQ-020 STREAM, FRAME_MAX bytes forwarded without last: further bytes SHALL NOT be forwarded, o_abort_cnt SHALL increment, and the block SHALL go to FLUSH; when the FRAME_MAX-th byte carries last=1, REQ-018 applies instead.
REQ-021 FLUSH: the block SHALL accept and discard granted bytes with o_rvalid=0 until an accepted byte has last=1, then go to GAP.
REQ-022 GAP: the block SHALL hold o_rvalid=0 for GAP_CYCLES cycles, then return to IDLE; requests arriving during GAP SHALL wait.
REQ-023 A 1-byte frame (last on the first byte) SHALL be forwarded as the preamble plus 1 byte, then go to GAP.
REQ-024 Simultaneous requests SHALL be served in round-robin order; a single persistent requester SHALL be re-granted after each GAP.
REQ-025 i_req_* of non-granted requesters SHALL be ignored, and their o_req_ready SHALL remain 0.

Reset
REQ-026 On rst_n low, the block SHALL asynchronously set: state IDLE; o_rvalid, o_rdata, o_req_ready, o_busy, o_frame_cnt and o_abort_cnt to 0; o_grant and the last-grant pointer to N_REQ-1, so requester 0 wins first.
REQ-027 Reset asserted mid-frame SHALL drop o_rvalid immediately; after release, the partial frame SHALL NOT be resumed or counted.

Structure
REQ-028 Package mhp_pkg SHALL hold MHP_PREAMBLE, MHP_FRAME_MAX (49 = 7 header + 42 payload bytes), MHP_GAP_CYCLES and the FSM state encoding.
REQ-029 The round-robin selection SHALL be a combinational sub-module named mhp_rr_pick (inputs: request vector, last grant; outputs: any and index).

Verification
REQ-030 The bench SHALL cover: requester 2 sends a 10-byte frame -> o_rdata sequence 55, the 10 bytes, then o_rvalid=0 for 3 cycles; o_frame_cnt=1.
REQ-031 The bench SHALL cover: requesters 0 and 3 both valid at IDLE after reset -> grant order 0, 3, 0.
REQ-032 The bench SHALL cover: requester 1 drops valid after 5 bytes -> o_rvalid falls after byte 5; o_abort_cnt=1; remaining bytes accepted and discarded until last; next grant after 3 gap cycles.
REQ-033 The bench SHALL cover: a 60-byte frame -> exactly 49 bytes forwarded after 55; o_abort_cnt=1; all 60 bytes accepted.
REQ-034 The bench SHALL cover: a 49-byte frame with last on byte 49 -> full forward; o_frame_cnt increments; o_abort_cnt unchanged.
REQ-035 The bench SHALL cover: rst_n pulsed low at byte 20 -> o_rvalid=0 asynchronously; counters 0; the next frame starts with 55 from requester 0.
